// File: rtl/usb_consts_pkg.sv
// -----------------------------------------------------------------------------
// usb_consts_pkg
// Shared definitions for the full-speed non-blocking IN endpoint controller:
// the per-endpoint state enum, packet buffer geometry and a byte-lane helper.
// -----------------------------------------------------------------------------
package usb_consts_pkg;

    // Lifecycle of one IN endpoint's armed packet.
    typedef enum logic [1:0] {
        StEmpty    = 2'd0,
        StReady    = 2'd1,
        StInFlight = 2'd2
    } ep_state_e;

    // Every packet buffer holds one maximum-size full-speed packet.
    localparam int unsigned BufBytes = 64;
    localparam int unsigned BufWords = 16;

    // Largest byte count software may arm (a full buffer).
    localparam logic [6:0] MaxArmSize = 7'd64;

    // Pick byte lane 'sel' out of a little-endian 32-bit SRAM word.
    function automatic logic [7:0] word_byte(input logic [31:0] word, input logic [1:0] sel);
        logic [7:0] b;
        case (sel)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            2'd3:    b = word[31:24];
            default: b = 8'd0;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/usb_in_ep_slot.sv
// -----------------------------------------------------------------------------
// usb_in_ep_slot
// State for one IN endpoint: Empty/Ready/InFlight FSM, armed buffer index and
// byte size, deferred-cancel flag and the sticky sent/pend status bits.
// All event inputs arrive already decoded for this endpoint.
//
// Ports
//   clk, rst_n            clock, async active-low reset
//   link_reset            USB bus reset: abandon any armed packet (pend)
//   newpkt/xfr_end/rollback  engine events, only when this ep is current
//   cancel                software cancel targeted at this ep
//   cfg_we/cfg_buf/cfg_size  arm request targeted at this ep
//   sent_clr/pend_clr     W1C for the status bits
//   state/buf_idx/size    current FSM state and armed packet descriptor
//   sent/pend             sticky status
//   cfg_reject            combinational: the arm request this cycle is refused
// -----------------------------------------------------------------------------
module usb_in_ep_slot
    import usb_consts_pkg::*;
#(
    parameter int unsigned BufW = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            link_reset,
    input  logic            newpkt,
    input  logic            xfr_end,
    input  logic            rollback,
    input  logic            cancel,
    input  logic            cfg_we,
    input  logic [BufW-1:0] cfg_buf,
    input  logic [6:0]      cfg_size,
    input  logic            sent_clr,
    input  logic            pend_clr,
    output ep_state_e       state,
    output logic [BufW-1:0] buf_idx,
    output logic [6:0]      size,
    output logic            sent,
    output logic            pend,
    output logic            cfg_reject
);

    ep_state_e       state_r, state_s;
    logic [BufW-1:0] buf_r, buf_s;
    logic [6:0]      size_r, size_s;
    logic            cpend_r, cpend_s;
    logic            sent_r, pend_r;
    logic            sent_set_s, pend_set_s;

    // Next-state logic: engine event first, then cancel on the resulting state, then arm.
    always_comb begin
        state_s    = state_r;
        buf_s      = buf_r;
        size_s     = size_r;
        cpend_s    = cpend_r;
        sent_set_s = 1'b0;
        pend_set_s = 1'b0;
        cfg_reject = 1'b0;

        if (link_reset) begin
            // Bus reset dominates; software traffic in the same cycle is dropped silently.
            if (state_r != StEmpty) begin
                state_s    = StEmpty;
                pend_set_s = 1'b1;
            end else begin
                state_s    = StEmpty;
            end
            cpend_s = 1'b0;
        end else begin
            case (state_r)
                StReady: begin
                    if (newpkt) begin
                        state_s = StInFlight;
                    end else begin
                        state_s = StReady;
                    end
                end
                StInFlight: begin
                    if (xfr_end) begin
                        // A pending cancel lost the race: the host got the data.
                        state_s    = StEmpty;
                        sent_set_s = 1'b1;
                        cpend_s    = 1'b0;
                    end else if (rollback) begin
                        if (cpend_r) begin
                            state_s    = StEmpty;
                            pend_set_s = 1'b1;
                            cpend_s    = 1'b0;
                        end else begin
                            state_s    = StReady;
                        end
                    end else begin
                        state_s = StInFlight;
                    end
                end
                default: begin
                    state_s = state_r;
                end
            endcase

            case (state_s)
                StReady: begin
                    if (cancel) begin
                        state_s    = StEmpty;
                        pend_set_s = 1'b1;
                    end else begin
                        state_s    = StReady;
                    end
                end
                StInFlight: begin
                    // Cannot pull data the engine is sending; resolve at termination.
                    cpend_s = cpend_s | cancel;
                end
                default: begin
                    cpend_s = cpend_s;
                end
            endcase

            if (cfg_we) begin
                if ((state_r == StEmpty) && (cfg_size <= MaxArmSize)) begin
                    state_s = StReady;
                    buf_s   = cfg_buf;
                    size_s  = cfg_size;
                end else begin
                    cfg_reject = 1'b1;
                end
            end else begin
                cfg_reject = 1'b0;
            end
        end
    end

    // State, descriptor and status registers; status sets win over W1C clears.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= StEmpty;
            buf_r   <= {BufW{1'b0}};
            size_r  <= 7'd0;
            cpend_r <= 1'b0;
            sent_r  <= 1'b0;
            pend_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            buf_r   <= buf_s;
            size_r  <= size_s;
            cpend_r <= cpend_s;
            sent_r  <= sent_set_s | (sent_r & ~sent_clr);
            pend_r  <= pend_set_s | (pend_r & ~pend_clr);
        end
    end

    assign state   = state_r;
    assign buf_idx = buf_r;
    assign size    = size_r;
    assign sent    = sent_r;
    assign pend    = pend_r;

endmodule

// File: rtl/usb_fs_nb_in_ep_ctrl.sv
// -----------------------------------------------------------------------------
// usb_fs_nb_in_ep_ctrl
// Non-blocking IN endpoint controller for a full-speed USB device. Software
// arms an endpoint with a buffer and byte count; the IN protocol engine pulls
// the packet byte by byte out of the shared buffer SRAM.
//
// Ports
//   clk_48mhz_i, rst_ni         clock, async active-low reset
//   link_reset_i                USB bus reset
//   cfg_we_i/cfg_ep_i/cfg_buf_i/cfg_size_i   arm an endpoint
//   cfg_cancel_i/cfg_cancel_ep_i             withdraw an armed packet
//   cfg_err_o                   1-cycle pulse after a refused arm request
//   in_ep_*_i                   current endpoint, get address and events
//   in_ep_has_data_o/in_ep_data_done_o       per-endpoint status to engine
//   in_ep_data_o                byte at the (1-cycle delayed) get address
//   mem_req_o/mem_addr_o/mem_rdata_i         buffer SRAM, 1-cycle read latency
//   sent_o/pend_o, sent_clr_i/pend_clr_i     sticky status with W1C
// -----------------------------------------------------------------------------
module usb_fs_nb_in_ep_ctrl
    import usb_consts_pkg::*;
#(
    parameter  int unsigned NumInEps         = 12,
    parameter  int unsigned MaxInPktSizeByte = 64,
    parameter  int unsigned NumBufs          = 32,
    localparam int unsigned PktW             = $clog2(MaxInPktSizeByte),
    localparam int unsigned BufW             = $clog2(NumBufs)
) (
    input  logic                clk_48mhz_i,
    input  logic                rst_ni,
    input  logic                link_reset_i,
    input  logic                cfg_we_i,
    input  logic [3:0]          cfg_ep_i,
    input  logic [BufW-1:0]     cfg_buf_i,
    input  logic [6:0]          cfg_size_i,
    input  logic                cfg_cancel_i,
    input  logic [3:0]          cfg_cancel_ep_i,
    output logic                cfg_err_o,
    input  logic [3:0]          in_ep_current_i,
    input  logic [PktW-1:0]     in_ep_get_addr_i,
    input  logic                in_ep_newpkt_i,
    input  logic                in_ep_xfr_end_i,
    input  logic                in_ep_rollback_i,
    output logic [NumInEps-1:0] in_ep_has_data_o,
    output logic [NumInEps-1:0] in_ep_data_done_o,
    output logic [7:0]          in_ep_data_o,
    output logic                mem_req_o,
    output logic [BufW+3:0]     mem_addr_o,
    input  logic [31:0]         mem_rdata_i,
    output logic [NumInEps-1:0] sent_o,
    output logic [NumInEps-1:0] pend_o,
    input  logic [NumInEps-1:0] sent_clr_i,
    input  logic [NumInEps-1:0] pend_clr_i
);

    ep_state_e           slot_state_s [NumInEps];
    logic [BufW-1:0]     slot_buf_s   [NumInEps];
    logic [6:0]          slot_size_s  [NumInEps];
    logic [NumInEps-1:0] slot_reject_s;
    logic [NumInEps-1:0] cur_hit_s;
    logic                cur_inflight_s;
    logic [BufW-1:0]     cur_buf_s;
    logic [1:0]          get_addr_q_r;
    logic                cfg_err_r;

    // Endpoint numbers beyond NumInEps never match a slot, so they are ignored.
    for (genvar e = 0; e < NumInEps; e++) begin : g_slot
        assign cur_hit_s[e] = (in_ep_current_i == 4'(e));

        usb_in_ep_slot #(
            .BufW (BufW)
        ) u_slot (
            .clk        (clk_48mhz_i),
            .rst_n      (rst_ni),
            .link_reset (link_reset_i),
            .newpkt     (in_ep_newpkt_i & cur_hit_s[e]),
            .xfr_end    (in_ep_xfr_end_i & cur_hit_s[e]),
            .rollback   (in_ep_rollback_i & cur_hit_s[e]),
            .cancel     (cfg_cancel_i & (cfg_cancel_ep_i == 4'(e))),
            .cfg_we     (cfg_we_i & (cfg_ep_i == 4'(e))),
            .cfg_buf    (cfg_buf_i),
            .cfg_size   (cfg_size_i),
            .sent_clr   (sent_clr_i[e]),
            .pend_clr   (pend_clr_i[e]),
            .state      (slot_state_s[e]),
            .buf_idx    (slot_buf_s[e]),
            .size       (slot_size_s[e]),
            .sent       (sent_o[e]),
            .pend       (pend_o[e]),
            .cfg_reject (slot_reject_s[e])
        );

        assign in_ep_has_data_o[e]  = (slot_state_s[e] != StEmpty);
        // Size 64 can never be reached by a 6-bit address: the engine ends at all-ones.
        assign in_ep_data_done_o[e] = cur_hit_s[e] & in_ep_has_data_o[e] &
                                      ({1'b0, in_ep_get_addr_i} >= slot_size_s[e]);
    end

    // One-hot select of the current endpoint's state and buffer (zero if out of range).
    always_comb begin
        cur_inflight_s = 1'b0;
        cur_buf_s      = {BufW{1'b0}};
        for (int e = 0; e < NumInEps; e++) begin
            cur_inflight_s = cur_inflight_s | (cur_hit_s[e] & (slot_state_s[e] == StInFlight));
            cur_buf_s      = cur_buf_s | (slot_buf_s[e] & {BufW{cur_hit_s[e]}});
        end
    end

    // Byte lane of the word the SRAM returns this cycle, plus the arm-error pulse.
    always_ff @(posedge clk_48mhz_i or negedge rst_ni) begin
        if (!rst_ni) begin
            get_addr_q_r <= 2'd0;
            cfg_err_r    <= 1'b0;
        end else begin
            get_addr_q_r <= in_ep_get_addr_i[1:0];
            cfg_err_r    <= |slot_reject_s;
        end
    end

    assign mem_req_o    = cur_inflight_s;
    assign mem_addr_o   = {cur_buf_s, in_ep_get_addr_i[PktW-1:2]};
    assign in_ep_data_o = cur_inflight_s ? word_byte(mem_rdata_i, get_addr_q_r) : 8'd0;
    assign cfg_err_o    = cfg_err_r;

endmodule

// File: tb/tb_usb_fs_nb_in_ep_ctrl.sv
// -----------------------------------------------------------------------------
// tb_usb_fs_nb_in_ep_ctrl
// Directed scenarios followed by random traffic. Each cycle the stimulus side
// pushes the expected outputs (from a rule-level endpoint model) into a queue;
// a monitor pops on the falling edge and compares against the DUT.
// -----------------------------------------------------------------------------
module tb_usb_fs_nb_in_ep_ctrl;

    localparam int NEP      = 12;
    localparam int E_EMPTY  = 0;
    localparam int E_READY  = 1;
    localparam int E_FLIGHT = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        link_reset = 1'b0;
    logic        cfg_we = 1'b0;
    logic [3:0]  cfg_ep = 4'd0;
    logic [4:0]  cfg_buf = 5'd0;
    logic [6:0]  cfg_size = 7'd0;
    logic        cfg_cancel = 1'b0;
    logic [3:0]  cfg_cancel_ep = 4'd0;
    logic        cfg_err;
    logic [3:0]  cur = 4'd0;
    logic [5:0]  ga = 6'd0;
    logic        newpkt = 1'b0, xfr_end = 1'b0, rollback = 1'b0;
    logic [11:0] has_data, data_done, sent, pend;
    logic [11:0] sent_clr = 12'd0, pend_clr = 12'd0;
    logic [7:0]  data;
    logic        mem_req;
    logic [8:0]  mem_addr;
    logic [31:0] mem_rdata = 32'd0;
    logic [31:0] sram [512];

    int total = 0;
    int bad   = 0;

    usb_fs_nb_in_ep_ctrl dut (
        .clk_48mhz_i       (clk),
        .rst_ni            (rst_n),
        .link_reset_i      (link_reset),
        .cfg_we_i          (cfg_we),
        .cfg_ep_i          (cfg_ep),
        .cfg_buf_i         (cfg_buf),
        .cfg_size_i        (cfg_size),
        .cfg_cancel_i      (cfg_cancel),
        .cfg_cancel_ep_i   (cfg_cancel_ep),
        .cfg_err_o         (cfg_err),
        .in_ep_current_i   (cur),
        .in_ep_get_addr_i  (ga),
        .in_ep_newpkt_i    (newpkt),
        .in_ep_xfr_end_i   (xfr_end),
        .in_ep_rollback_i  (rollback),
        .in_ep_has_data_o  (has_data),
        .in_ep_data_done_o (data_done),
        .in_ep_data_o      (data),
        .mem_req_o         (mem_req),
        .mem_addr_o        (mem_addr),
        .mem_rdata_i       (mem_rdata),
        .sent_o            (sent),
        .pend_o            (pend),
        .sent_clr_i        (sent_clr),
        .pend_clr_i        (pend_clr)
    );

    always #5 clk = ~clk;

    // Buffer SRAM with one cycle of read latency.
    always @(posedge clk) begin
        if (mem_req) mem_rdata <= sram[mem_addr];
    end

    // ---------------- reference model ----------------
    int          m_st   [NEP];
    int          m_buf  [NEP];
    int          m_size [NEP];
    bit          m_cp   [NEP];
    logic [11:0] m_sent, m_pend;
    bit          m_err;
    logic [31:0] m_rd = 32'd0;
    int          m_sel;

    typedef struct {
        logic [11:0] has, done, snt, pnd;
        logic        err, req;
        logic [8:0]  addr;
        logic [7:0]  dat;
    } exp_t;

    exp_t q[$];

    task automatic model_reset();
        for (int e = 0; e < NEP; e++) begin
            m_st[e] = E_EMPTY; m_buf[e] = 0; m_size[e] = 0; m_cp[e] = 1'b0;
        end
        m_sent = 12'd0; m_pend = 12'd0; m_err = 1'b0; m_sel = 0;
    endtask

    function automatic exp_t model_expect();
        exp_t x;
        int   c;
        logic [31:0] w;
        c = int'(cur);
        x.err = m_err; x.snt = m_sent; x.pnd = m_pend;
        x.has = 12'd0; x.done = 12'd0;
        for (int e = 0; e < NEP; e++) begin
            x.has[e]  = (m_st[e] != E_EMPTY);
            x.done[e] = (c == e) && (m_st[e] != E_EMPTY) && (int'(ga) >= m_size[e]);
        end
        x.req  = (c < NEP) && (m_st[c] == E_FLIGHT);
        x.addr = x.req ? 9'(m_buf[c] * 16 + int'(ga) / 4) : 9'd0;
        w      = m_rd >> (8 * m_sel);
        x.dat  = x.req ? w[7:0] : 8'd0;
        return x;
    endfunction

    task automatic model_update();
        int c;
        int ce;
        bit arm_ok;
        logic [11:0] sset, pset;
        c = int'(cur); ce = int'(cfg_cancel_ep);
        sset = 12'd0; pset = 12'd0;
        arm_ok = 1'b0;
        if (c < NEP && m_st[c] == E_FLIGHT) m_rd = sram[m_buf[c] * 16 + int'(ga) / 4];
        m_sel = int'(ga) % 4;
        m_err = 1'b0;
        if (int'(cfg_ep) < NEP) arm_ok = (m_st[cfg_ep] == E_EMPTY);
        if (link_reset) begin
            for (int e = 0; e < NEP; e++) begin
                if (m_st[e] != E_EMPTY) pset[e] = 1'b1;
                m_st[e] = E_EMPTY; m_cp[e] = 1'b0;
            end
        end else begin
            if (c < NEP) begin
                if (m_st[c] == E_READY && newpkt) m_st[c] = E_FLIGHT;
                else if (m_st[c] == E_FLIGHT && xfr_end) begin
                    m_st[c] = E_EMPTY; sset[c] = 1'b1; m_cp[c] = 1'b0;
                end else if (m_st[c] == E_FLIGHT && rollback) begin
                    if (m_cp[c]) begin m_st[c] = E_EMPTY; pset[c] = 1'b1; m_cp[c] = 1'b0; end
                    else m_st[c] = E_READY;
                end
            end
            if (cfg_cancel && ce < NEP) begin
                if (m_st[ce] == E_READY) begin m_st[ce] = E_EMPTY; pset[ce] = 1'b1; end
                else if (m_st[ce] == E_FLIGHT) m_cp[ce] = 1'b1;
            end
            if (cfg_we && int'(cfg_ep) < NEP) begin
                if (arm_ok && int'(cfg_size) <= 64) begin
                    m_st[cfg_ep] = E_READY; m_buf[cfg_ep] = int'(cfg_buf); m_size[cfg_ep] = int'(cfg_size);
                end else m_err = 1'b1;
            end
        end
        m_sent = sset | (m_sent & ~sent_clr);
        m_pend = pset | (m_pend & ~pend_clr);
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic idle_pulses();
        cfg_we = 1'b0; cfg_cancel = 1'b0; newpkt = 1'b0; xfr_end = 1'b0; rollback = 1'b0;
        link_reset = 1'b0; sent_clr = 12'd0; pend_clr = 12'd0;
    endtask

    task automatic step();
        q.push_back(model_expect());
        model_update();
        @(posedge clk);
        #1;
        idle_pulses();
    endtask

    task automatic arm(input int ep, input int b, input int sz);
        cfg_we = 1'b1; cfg_ep = 4'(ep); cfg_buf = 5'(b); cfg_size = 7'(sz);
        step();
    endtask

    task automatic engine(input int ep, input int a, input bit np, input bit xe, input bit rb);
        cur = 4'(ep); ga = 6'(a); newpkt = np; xfr_end = xe; rollback = rb;
        step();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
        end
    endtask

    // ---------------- monitor ----------------
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                x = q.pop_front();
                chk("has_data",  32'(has_data),  32'(x.has));
                chk("data_done", 32'(data_done), 32'(x.done));
                chk("sent",      32'(sent),      32'(x.snt));
                chk("pend",      32'(pend),      32'(x.pnd));
                chk("cfg_err",   32'(cfg_err),   32'(x.err));
                chk("mem_req",   32'(mem_req),   32'(x.req));
                chk("in_data",   32'(data),      32'(x.dat));
                if (x.req) chk("mem_addr", 32'(mem_addr), 32'(x.addr));
            end
        end
    end

    // ---------------- scenarios ----------------
    initial begin
        for (int i = 0; i < 512; i++) sram[i] = $urandom;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(); step();

        // Basic packet: ep2, buffer 5, three bytes.
        arm(2, 5, 3);
        engine(2, 0, 1'b1, 1'b0, 1'b0);
        for (int a = 0; a < 4; a++) engine(2, a, 1'b0, 1'b0, 1'b0);
        engine(2, 3, 1'b0, 1'b1, 1'b0);
        step();

        // Rollback keeps the data for a retry.
        arm(1, 7, 10);
        engine(1, 0, 1'b1, 1'b0, 1'b0);
        engine(1, 4, 1'b0, 1'b0, 1'b1);
        engine(1, 0, 1'b1, 1'b0, 1'b0);
        for (int a = 0; a < 11; a++) engine(1, a, 1'b0, 1'b0, 1'b0);
        engine(1, 10, 1'b0, 1'b1, 1'b0);
        step();

        // Cancel while in flight, resolved by rollback then by xfr_end.
        arm(3, 9, 8);
        engine(3, 0, 1'b1, 1'b0, 1'b0);
        cfg_cancel = 1'b1; cfg_cancel_ep = 4'd3; engine(3, 2, 1'b0, 1'b0, 1'b0);
        engine(3, 2, 1'b0, 1'b0, 1'b1);
        step();
        arm(3, 9, 8);
        engine(3, 0, 1'b1, 1'b0, 1'b0);
        cfg_cancel = 1'b1; cfg_cancel_ep = 4'd3; engine(3, 5, 1'b0, 1'b0, 1'b0);
        engine(3, 8, 1'b0, 1'b1, 1'b0);
        step();
        // Cancel of a Ready endpoint and cancel coincident with rollback.
        arm(6, 3, 5);
        cfg_cancel = 1'b1; cfg_cancel_ep = 4'd6; step();
        arm(6, 3, 5);
        engine(6, 0, 1'b1, 1'b0, 1'b0);
        cfg_cancel = 1'b1; cfg_cancel_ep = 4'd6; engine(6, 1, 1'b0, 1'b0, 1'b1);
        step();

        // Refused arm requests: already armed, oversize, out-of-range endpoint.
        arm(5, 11, 20);
        arm(5, 12, 4);
        step();
        arm(5, 11, 65);
        arm(13, 1, 4);
        step();

        // Size 0 and size 64 boundaries.
        arm(7, 1, 0);
        engine(7, 0, 1'b0, 1'b0, 1'b0);
        arm(8, 2, 64);
        engine(8, 0, 1'b1, 1'b0, 1'b0);
        for (int a = 0; a < 64; a++) engine(8, a, 1'b0, 1'b0, 1'b0);
        engine(8, 63, 1'b0, 1'b1, 1'b0);

        // Bus reset with ep0 and ep4 armed (ep5 and ep7 still armed too).
        pend_clr = 12'hFFF; sent_clr = 12'hFFF; step();
        cfg_cancel = 1'b1; cfg_cancel_ep = 4'd5; step();
        cfg_cancel = 1'b1; cfg_cancel_ep = 4'd7; step();
        pend_clr = 12'hFFF; step();
        arm(0, 4, 12);
        arm(4, 6, 30);
        link_reset = 1'b1; step();
        step();
        // Set coincident with W1C clear keeps the bit.
        arm(9, 8, 2);
        engine(9, 0, 1'b1, 1'b0, 1'b0);
        sent_clr = 12'hFFF; engine(9, 2, 1'b0, 1'b1, 1'b0);
        step();

        // Reset mid-packet: no pend is recorded.
        arm(10, 13, 40);
        engine(10, 0, 1'b1, 1'b0, 1'b0);
        engine(10, 5, 1'b0, 1'b0, 1'b0);
        do_reset();
        step(); step();

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            int r;
            cur = 4'($urandom_range(0, 15) < 13 ? $urandom_range(0, 11) : $urandom_range(12, 15));
            ga  = 6'($urandom_range(0, 63));
            r   = $urandom_range(0, 9);
            newpkt   = (r < 3);
            xfr_end  = (r == 3) || (r == 4);
            rollback = (r == 5);
            cfg_we   = ($urandom_range(0, 5) == 0);
            cfg_ep   = 4'($urandom_range(0, 13));
            cfg_buf  = 5'($urandom_range(0, 31));
            cfg_size = 7'($urandom_range(0, 9) == 0 ? $urandom_range(60, 70) : $urandom_range(0, 64));
            cfg_cancel    = ($urandom_range(0, 11) == 0);
            cfg_cancel_ep = 4'($urandom_range(0, 13));
            link_reset    = ($urandom_range(0, 199) == 0);
            sent_clr = ($urandom_range(0, 9) == 0) ? 12'($urandom) : 12'd0;
            pend_clr = ($urandom_range(0, 9) == 0) ? 12'($urandom) : 12'd0;
            step();
        end

        cur = 4'd0;
        step();
        repeat (2) @(posedge clk);
        #1;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/usb_fs_nb_in_ep_ctrl.md
USB_FS_NB_IN_EP_CTRL -- requirements
Module: usb_fs_nb_in_ep_ctrl

Interface
REQ-001 Parameter NumInEps, default 12: number of IN endpoints.
REQ-002 Parameter MaxInPktSizeByte, default 64: max packet bytes; PktW = clog2(MaxInPktSizeByte).
REQ-003 Parameter NumBufs, default 32: packet buffers, each 64 bytes = 16 words; BufW = clog2(NumBufs).
REQ-004 Clock and reset: one clock and an active-low reset; reset is asynchronous and active-low.
REQ-005 clk_48mhz_i  in  1  clock.
REQ-006 rst_ni  in  1  async active-low reset.
REQ-007 link_reset_i  in  1  USB bus reset.
REQ-008 cfg_we_i / cfg_ep_i / cfg_buf_i / cfg_size_i  in  1/4/BufW/7  arm endpoint cfg_ep_i with buffer and byte size 0..64.
REQ-009 cfg_cancel_i / cfg_cancel_ep_i  in  1/4  software withdraws an armed packet.
REQ-010 cfg_err_o  out  1  pulse: rejected write.
REQ-011 in_ep_current_i, in_ep_get_addr_i, in_ep_newpkt_i, in_ep_xfr_end_i, in_ep_rollback_i  in  4/PktW/1/1/1  from the IN protocol engine.
REQ-012 in_ep_has_data_o / in_ep_data_done_o  out  NumInEps each  to the engine.
REQ-013 in_ep_data_o  out  8  byte for the current get address.
REQ-014 mem_req_o / mem_addr_o / mem_rdata_i  out 1 / out BufW+4 / in 32  buffer SRAM, 1-cycle read latency.
REQ-015 sent_o / pend_o  out  NumInEps each  sticky status; sent_clr_i / pend_clr_i  in  NumInEps  W1C.

Function
REQ-016 Per-endpoint FSM: StEmpty, StReady, StInFlight.
REQ-017 Endpoint numbers >= NumInEps are ignored on every input.
REQ-018 cfg_we_i in StEmpty -> latch buf/size and go StReady; in any other state -> ignored, cfg_err_o pulses for 1 cycle.
REQ-019 cfg_size_i > 64 -> rejected, cfg_err_o pulses.
REQ-020 in_ep_has_data_o[e] = 1 iff e is in StReady or StInFlight.
REQ-021 in_ep_newpkt_i with current e in StReady -> StInFlight.
REQ-022 in_ep_xfr_end_i with e in StInFlight -> StEmpty, sent_o[e] set.
REQ-023 in_ep_rollback_i -> StReady; the data is kept for retry.
REQ-024 cfg_cancel_i in StReady -> StEmpty, pend_o[e] set.
REQ-025 cfg_cancel_i in StInFlight -> cancel_pend[e] set, no state change.
REQ-026 Cancel resolved at termination: xfr_end -> counted sent; rollback -> StEmpty, pend_o[e] set.
REQ-027 xfr_end/rollback and cancel for the same e in the same cycle: the engine event is applied first, then the cancel rules apply to the resulting state.
REQ-028 in_ep_data_done_o[e] = 1 only for e == in_ep_current_i, when {1'b0,in_ep_get_addr_i} >= size[e].
REQ-029 Size 64 never asserts data_done; the engine ends the packet at get address all-ones.
REQ-030 Size 0 asserts data_done immediately, giving a zero-length packet.
REQ-031 mem_req_o is asserted every cycle the current e is StInFlight.
REQ-032 mem_addr_o = {buf[current], get_addr[5:2]}.
REQ-033 in_ep_data_o = byte get_addr_q[1:0] of mem_rdata_i, where get_addr_q is the 1-cycle-delayed get address; latency is 1 cycle after a get address change.
REQ-034 in_ep_data_o = 0 when the current e is not StInFlight.
REQ-035 link_reset_i: every StReady/StInFlight -> StEmpty, pend_o set for those endpoints, cancel_pend cleared.
REQ-036 Status sets take priority over W1C clears in the same cycle.

Reset
REQ-037 All FSMs reset to StEmpty; buf/size, cancel_pend, sent_o, pend_o, get_addr_q, cfg_err_o and mem_req_o reset to 0.
REQ-038 Reset mid-packet abandons the packet without setting pend_o.

Structure
REQ-039 The FSM state enum and the buffer geometry constants (bytes per buffer, words per buffer) go in usb_consts_pkg.
REQ-040 One sub-module, usb_in_ep_slot, is instantiated per endpoint; it holds the FSM, buf/size and status bits.
REQ-041 Target size is 120-400 lines of RTL.

Verification
REQ-042 Arm ep2 buf5 size 3 -> has_data[2]=1; newpkt; get addresses 0..3 -> mem_addr 0x50; data_done[2] at get address 3; xfr_end -> sent_o[2]=1, state StEmpty.
REQ-043 Arm ep1, newpkt, rollback -> has_data[1] stays 1; second newpkt and xfr_end -> sent_o[1]=1, pend_o[1]=0.
REQ-044 Cancel ep3 while StInFlight, then rollback -> pend_o[3]=1, has_data[3]=0; repeat with xfr_end -> sent_o[3]=1.
REQ-045 cfg_we_i to an armed ep -> cfg_err_o 1-cycle pulse, original size kept; size 65 -> rejected.
REQ-046 Size 0 -> data_done at get address 0; size 64 -> data_done never set across get addresses 0..63.
REQ-047 link_reset_i with ep0 and ep4 armed -> both StEmpty, pend_o = 0x011; sent_clr_i coincident with a set -> bit stays 1.
